// File: rtl/fc_updatefc_dllp_gen.sv
// UpdateFC DLLP generator: latches credit update requests, builds the DLLP body plus
// 16-bit DLLP CRC, and hands it to the transmit arbiter over valid/ready with periodic resend.
module fc_updatefc_dllp_gen #(
  parameter logic [1:0]  FC_TYPE      = 2'b00,
  parameter logic [2:0]  VC_ID        = 3'd0,
  parameter int unsigned TIMER_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fc_init_done_i,
  input  logic [7:0]  updatefc_hdr_credit_i,
  input  logic [11:0] updatefc_data_credit_i,
  input  logic        updatefc_send_i,
  output logic        dllp_valid_o,
  output logic [47:0] dllp_o,
  input  logic        dllp_ready_i,
  output logic        pending_o,
  output logic [15:0] sent_cnt_o
);

  localparam logic [7:0] TYPE_BYTE =
    ((FC_TYPE == 2'b00) ? 8'h80 : (FC_TYPE == 2'b01) ? 8'h90 : 8'hA0) | {5'b00000, VC_ID};
  localparam logic [15:0] TIMER_LAST = 16'(TIMER_CYCLES - 1);

  typedef enum logic [1:0] {DISABLED, IDLE, SEND} state_t;

  state_t      state, state_nxt;
  logic [15:0] timer;
  logic [7:0]  pend_hdr, last_hdr;
  logic [11:0] pend_data, last_data;
  logic        capture, load, accept, expire;
  logic [31:0] body;
  logic [15:0] crc;

  // Serial DLLP CRC: bytes in transmit order, each byte LSB first; result is
  // complemented and bit-reversed within each byte for placement on the wire.
  function automatic logic [15:0] dllp_crc(input logic [31:0] b);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 3; k >= 0; k--) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ b[8*k + i];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
      end
    end
    for (int j = 0; j < 8; j++) begin
      r[8 + j] = ~c[15 - j];
      r[j]     = ~c[7 - j];
    end
    return r;
  endfunction

  assign body = {TYPE_BYTE, 2'b00, pend_hdr[7:2], pend_hdr[1:0], 2'b00, pend_data[11:8],
                 pend_data[7:0]};
  assign crc  = dllp_crc(body);

  assign capture = updatefc_send_i & fc_init_done_i & (state != DISABLED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DISABLED;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    expire    = 1'b0;
    case (state)
      DISABLED: if (fc_init_done_i) state_nxt = IDLE;
      IDLE: begin
        if (!fc_init_done_i) begin
          state_nxt = DISABLED;
        end else if (pending_o) begin
          load      = 1'b1;
          state_nxt = SEND;
        end else if (timer == TIMER_LAST) begin
          expire = 1'b1;
        end
      end
      SEND: begin
        if (dllp_ready_i) begin
          accept    = 1'b1;
          state_nxt = fc_init_done_i ? IDLE : DISABLED;
        end
      end
      default: state_nxt = DISABLED;
    endcase
  end

  // A fresh request always beats both the load clear and a timer resend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_o <= 1'b0;
      pend_hdr  <= '0;
      pend_data <= '0;
    end else if (state == DISABLED) begin
      pending_o <= 1'b0;
    end else if (capture) begin
      pending_o <= 1'b1;
      pend_hdr  <= updatefc_hdr_credit_i;
      pend_data <= updatefc_data_credit_i;
    end else if (load) begin
      pending_o <= 1'b0;
    end else if (expire) begin
      pending_o <= 1'b1;
      pend_hdr  <= last_hdr;
      pend_data <= last_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state != IDLE || capture || expire) begin
      timer <= '0;
    end else if (!pending_o) begin
      timer <= timer + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dllp_valid_o <= 1'b0;
      dllp_o       <= '0;
      last_hdr     <= '0;
      last_data    <= '0;
      sent_cnt_o   <= '0;
    end else begin
      if (load) begin
        dllp_valid_o <= 1'b1;
        dllp_o       <= {body, crc};
        last_hdr     <= pend_hdr;
        last_data    <= pend_data;
      end else if (accept) begin
        dllp_valid_o <= 1'b0;
        sent_cnt_o   <= sent_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fc_updatefc_dllp_gen.sv
// Bench for fc_updatefc_dllp_gen: directed scenarios plus random traffic, scoreboarded
// against a cycle-level reference model of the credit advertisement rules.
module tb_fc_updatefc_dllp_gen;

  localparam int TC = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic [7:0]  hdr;
  logic [11:0] data;
  logic        send;
  logic        ready;
  logic        dllp_valid;
  logic [47:0] dllp;
  logic        pending;
  logic [15:0] sent_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [47:0] exp_q[$];

  fc_updatefc_dllp_gen #(.FC_TYPE(2'b00), .VC_ID(3'd0), .TIMER_CYCLES(TC)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .fc_init_done_i        (init_done),
    .updatefc_hdr_credit_i (hdr),
    .updatefc_data_credit_i(data),
    .updatefc_send_i       (send),
    .dllp_valid_o          (dllp_valid),
    .dllp_o                (dllp),
    .dllp_ready_i          (ready),
    .pending_o             (pending),
    .sent_cnt_o            (sent_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [31:0] b);
    int bits[$];
    int c;
    logic [15:0] r;
    for (int k = 3; k >= 0; k--)
      for (int i = 0; i < 8; i++) bits.push_back(int'((b >> (8*k + i)) & 32'd1));
    c = 'hFFFF;
    foreach (bits[n]) begin
      c = c << 1;
      if (((c >> 16) & 1) != bits[n]) c = c ^ 'h100B;
      c = c & 'hFFFF;
    end
    c = (~c) & 'hFFFF;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < 8) r[8 + k] = 1'((c >> (15 - k)) & 1);
      else       r[k - 8] = 1'((c >> (15 - k)) & 1);
    end
    return r;
  endfunction

  function automatic logic [47:0] exp_dllp(input int h, input int d);
    logic [31:0] b;
    b = 32'('h80 * (2**24) + (h / 4) * (2**16) + (h % 4) * (2**14) + (d / 256) * (2**8) + d % 256);
    return {b, ref_crc(b)};
  endfunction

  // Reference model: enabled / outstanding / pending / idle-count bookkeeping.
  bit m_en, m_out, m_pend, cap;
  int m_ph, m_pd, m_lh, m_ld, m_idle, m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en = 0; m_out = 0; m_pend = 0;
      m_ph = 0; m_pd = 0; m_lh = 0; m_ld = 0; m_idle = 0; m_cnt = 0;
      exp_q.delete();
    end else begin
      cap = send && init_done && m_en;
      if (!m_en) begin
        m_pend = 0;
        m_idle = 0;
        if (init_done) m_en = 1;
      end else if (m_out) begin
        if (ready) begin
          m_out = 0;
          m_cnt = (m_cnt + 1) % 65536;
          m_idle = 0;
          if (!init_done) m_en = 0;
        end
        if (cap) begin m_pend = 1; m_ph = hdr; m_pd = data; end
      end else begin
        if (!init_done) begin
          m_en = 0;
        end else if (m_pend) begin
          exp_q.push_back(exp_dllp(m_ph, m_pd));
          m_lh = m_ph; m_ld = m_pd;
          m_pend = 0;
          m_out = 1;
        end else if (m_idle == TC - 1) begin
          m_pend = 1; m_ph = m_lh; m_pd = m_ld;
          m_idle = 0;
        end else begin
          m_idle++;
        end
        if (cap) begin m_pend = 1; m_ph = hdr; m_pd = data; m_idle = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", dllp_valid, m_out);
      check("pending", pending, m_pend);
      check("sent_cnt", sent_cnt, m_cnt);
      if (dllp_valid) begin
        check("dllp_queued", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("dllp", dllp, exp_q[0]);
          if (ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] h, input logic [11:0] d);
    hdr = h; data = d; send = 1'b1;
    step();
    send = 1'b0;
  endtask

  task automatic wait_valid(input int max, input string name);
    int n;
    n = 0;
    while (!dllp_valid && n < max) begin
      step();
      n++;
    end
    check(name, dllp_valid, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, low;
    rst_n = 1'b0; init_done = 1'b0; hdr = '0; data = '0; send = 1'b0; ready = 1'b0;
    repeat (3) step();
    check("rst_valid", dllp_valid, 0);
    check("rst_dllp", dllp, 48'h0);
    check("rst_cnt", sent_cnt, 0);
    rst_n = 1'b1;

    // Basic send and latency
    init_done = 1'b1; ready = 1'b1;
    repeat (5) step();
    pulse(8'h12, 12'h345);
    check("t1_lat1", dllp_valid, 0);
    step();
    check("t1_lat2", dllp_valid, 1);
    check("t1_body", dllp[47:16], 32'h80048345);
    step();
    check("t1_cnt", sent_cnt, 1);

    // Stall, request during stall, one-cycle bubble after accept
    ready = 1'b0;
    pulse(8'h30, 12'h111);
    wait_valid(10, "t2_valid1");
    pulse(8'h20, 12'h010);
    repeat (4) step();
    ready = 1'b1;
    step();
    check("t2_bubble", dllp_valid, 0);
    ready = 1'b0;
    step();
    check("t2_valid2", dllp_valid, 1);
    check("t2_body2", dllp[47:16], 32'h80080010);
    ready = 1'b1;
    step();

    // Coalescing of back-to-back requests
    ready = 1'b0;
    pulse(8'h40, 12'h200);
    wait_valid(10, "t3_valid1");
    pulse(8'h21, 12'h0AA);
    pulse(8'h22, 12'h0BB);
    pulse(8'h23, 12'h0CC);
    step();
    ready = 1'b1;
    step();
    check("t3_bubble", dllp_valid, 0);
    step();
    check("t3_valid2", dllp_valid, 1);
    check("t3_b1b2", dllp[39:24], 16'h08C0);
    step();
    check("t3_no_extra", dllp_valid, 0);

    // Periodic resend spacing
    wait_valid(40, "t4_resend1");
    c1 = cyc;
    step();
    wait_valid(40, "t4_resend2");
    c2 = cyc;
    check("t4_period", c2 - c1, 18);

    // Disabled behaviour and init drop mid-send
    init_done = 1'b0;
    repeat (2) step();
    pulse(8'h55, 12'h555);
    pulse(8'h66, 12'h666);
    step();
    check("t5_pend", pending, 0);
    check("t5_valid", dllp_valid, 0);
    init_done = 1'b1;
    repeat (2) step();
    ready = 1'b0;
    pulse(8'h77, 12'h777);
    wait_valid(10, "t5_valid1");
    init_done = 1'b0;
    repeat (3) step();
    check("t5_hold", dllp_valid, 1);
    ready = 1'b1;
    step();
    check("t5_drop", dllp_valid, 0);
    pulse(8'h88, 12'h888);
    repeat (3) step();
    check("t5_dis_pend", pending, 0);
    check("t5_dis_valid", dllp_valid, 0);

    // Async reset mid-send
    init_done = 1'b1; ready = 1'b0;
    repeat (2) step();
    pulse(8'h99, 12'h999);
    wait_valid(10, "t6_valid");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_valid_rst", dllp_valid, 0);
    check("t6_cnt_rst", sent_cnt, 0);
    check("t6_pend_rst", pending, 0);
    repeat (2) step();
    rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t6_nostale", dllp_valid, 0);
    end

    // Random traffic
    low = 0;
    for (int i = 0; i < 2500; i++) begin
      if (low > 0) begin
        low--;
        init_done = (low == 0);
      end else if ($urandom_range(399) == 0) begin
        low = $urandom_range(30, 5);
        init_done = 1'b0;
      end
      send  = ($urandom_range(4) == 0);
      hdr   = 8'($urandom);
      data  = 12'($urandom);
      ready = ($urandom_range(2) != 0);
      step();
    end
    send = 1'b0; init_done = 1'b1; ready = 1'b1;
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
